// File: rtl/timer_led_mmio.sv
// Memory-mapped timer / systick / LED / digit-display responder.
// Single-cycle writes, combinational zero-wait-state reads.
module timer_led_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
  parameter logic [31:0] TIMER_RST_TH = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic        irq,
  output logic [11:0] leds,
  output logic [11:0] digi
);

  localparam logic [2:0] IDX_TH      = 3'd0;
  localparam logic [2:0] IDX_TL      = 3'd1;
  localparam logic [2:0] IDX_TCON    = 3'd2;
  localparam logic [2:0] IDX_LED     = 3'd3;
  localparam logic [2:0] IDX_DIGI    = 3'd4;
  localparam logic [2:0] IDX_SYSTICK = 3'd5;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [11:0] led_reg;
  logic [11:0] digi_reg;
  logic [31:0] systick;

  logic [2:0]  idx;
  logic        hit;
  logic        wr_en;
  logic        unused_addr;

  assign idx         = MemBus_Address[4:2];
  assign hit         = (MemBus_Address[31:5] == BASE_ADDR[31:5]) && (idx <= IDX_SYSTICK);
  assign wr_en       = MemWrite && hit;
  assign unused_addr = ^MemBus_Address[1:0];

  // Counter update first; a same-cycle bus write to TL/TCON then takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      th       <= TIMER_RST_TH;
      tl       <= 32'h0;
      tcon     <= 3'b000;
      led_reg  <= 12'h000;
      digi_reg <= 12'h000;
      systick  <= 32'h0;
    end else begin
      systick <= systick + 32'd1;
      if (tcon[0]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[1]) begin
            tcon[2] <= 1'b1;
          end
        end else begin
          tl <= tl + 32'd1;
        end
      end
      if (wr_en) begin
        case (idx)
          IDX_TH:   th       <= MemBus_Write_Data;
          IDX_TL:   tl       <= MemBus_Write_Data;
          IDX_TCON: tcon     <= MemBus_Write_Data[2:0];
          IDX_LED:  led_reg  <= MemBus_Write_Data[11:0];
          IDX_DIGI: digi_reg <= MemBus_Write_Data[11:0];
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    Device_Read_Data = 32'h0;
    if (MemRead && hit) begin
      case (idx)
        IDX_TH:      Device_Read_Data = th;
        IDX_TL:      Device_Read_Data = tl;
        IDX_TCON:    Device_Read_Data = {29'h0, tcon};
        IDX_LED:     Device_Read_Data = {20'h0, led_reg};
        IDX_DIGI:    Device_Read_Data = {20'h0, digi_reg};
        IDX_SYSTICK: Device_Read_Data = systick;
        default:     Device_Read_Data = 32'h0;
      endcase
    end
  end

  assign irq  = tcon[2];
  assign leds = led_reg;
  assign digi = digi_reg;

endmodule
